nlms_weight_update: RTL and testbench

//  Weight-update engine that closes the LMS loop. Consumes error e, energy n and the reference taps;

---
 rtl/nlms_weight_update.sv | 158 +++++++++++++++
 tb/tb_nlms_weight_update.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nlms_weight_update.sv
// NLMS weight-update engine: serial restoring divider for the normalised step,
// then one saturating weight update per cycle across all taps.
module nlms_weight_update #(
    parameter int TAPS     = 32,
    parameter int DW       = 14,
    parameter int WW       = 16,
    parameter int FRAC     = 16,
    parameter int MU_SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DW-1:0]        e,
    input  logic [31:0]          n,
    input  logic [TAPS*DW-1:0]   ref_flat,
    input  logic                 clr_w,
    output logic                 busy,
    output logic                 done,
    output logic [TAPS*WW-1:0]   weight_out
);

    localparam int NW = DW + FRAC;
    localparam int PW = WW + DW;
    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CW = $clog2(NW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [NW-1:0] QMAX = NW'(2**(WW-1) - 1);

    logic [1:0]          state_reg;
    logic                e_neg_reg;
    logic [31:0]         n_snap_reg;
    logic [TAPS*DW-1:0]  ref_snap_reg;
    logic [NW-1:0]       num_reg;
    logic [31:0]         rem_reg;
    logic [NW-1:0]       quo_reg;
    logic [CW-1:0]       bit_cnt_reg;
    logic [IW-1:0]       tap_reg;
    logic [TAPS*WW-1:0]  w_flat;

    logic                accept;
    logic [DW-1:0]       e_abs;
    logic [32:0]         rem_shift;
    logic                rem_ge;
    logic [31:0]         rem_sub;
    logic [WW-1:0]       mag;
    logic signed [WW-1:0] step_val;
    logic [DW-1:0]       ref_k;
    logic signed [PW-1:0] step_ext;
    logic signed [PW-1:0] ref_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] delta;
    logic [WW-1:0]       w_cur;
    logic signed [PW:0]  w_ext;
    logic signed [PW:0]  d_ext;
    logic signed [PW:0]  sum;
    logic [WW-1:0]       w_new;

    // The DONE cycle already accepts a new request so runs can be chained.
    assign accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign e_abs  = e[DW-1] ? (~e + 1'b1) : e;

    assign rem_shift = {rem_reg, num_reg[NW-1]};
    assign rem_ge    = (rem_shift >= {1'b0, n_snap_reg});
    assign rem_sub   = rem_shift[31:0] - n_snap_reg;

    assign mag      = (quo_reg > QMAX) ? QMAX[WW-1:0] : quo_reg[WW-1:0];
    assign step_val = e_neg_reg ? -$signed(mag) : $signed(mag);

    assign ref_k    = ref_snap_reg[tap_reg*DW +: DW];
    assign step_ext = {{DW{step_val[WW-1]}}, step_val};
    assign ref_ext  = {{WW{ref_k[DW-1]}}, ref_k};
    assign prod     = step_ext * ref_ext;
    assign delta    = prod >>> MU_SHIFT;

    assign w_cur = w_flat[tap_reg*WW +: WW];
    assign w_ext = {{(PW+1-WW){w_cur[WW-1]}}, w_cur};
    assign d_ext = {delta[PW-1], delta};
    assign sum   = w_ext + d_ext;

    always_comb begin
        w_new = sum[WW-1:0];
        if (sum > $signed({{(PW+2-WW){1'b0}}, {(WW-1){1'b1}}}))
            w_new = {1'b0, {(WW-1){1'b1}}};
        else if (sum < $signed({{(PW+2-WW){1'b1}}, {(WW-1){1'b0}}}))
            w_new = {1'b1, {(WW-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst || clr_w) begin
            state_reg    <= S_IDLE;
            e_neg_reg    <= 1'b0;
            n_snap_reg   <= '0;
            ref_snap_reg <= '0;
            num_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            bit_cnt_reg  <= '0;
            tap_reg      <= '0;
        end else begin
            if (accept) begin
                e_neg_reg    <= e[DW-1];
                n_snap_reg   <= n;
                ref_snap_reg <= ref_flat;
                num_reg      <= {e_abs, {FRAC{1'b0}}};
                rem_reg      <= '0;
                quo_reg      <= '0;
                bit_cnt_reg  <= '0;
                tap_reg      <= '0;
                // A zero quotient is the whole answer when there is nothing to divide.
                state_reg    <= ((n == 32'd0) || (e == '0)) ? S_UPD : S_DIV;
            end else begin
                case (state_reg)
                    S_DIV: begin
                        rem_reg     <= rem_ge ? rem_sub : rem_shift[31:0];
                        quo_reg     <= {quo_reg[NW-2:0], rem_ge};
                        num_reg     <= num_reg << 1;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == CW'(NW-1))
                            state_reg <= S_UPD;
                    end
                    S_UPD: begin
                        if (tap_reg == IW'(TAPS-1)) begin
                            tap_reg   <= '0;
                            state_reg <= S_DONE;
                        end else begin
                            tap_reg <= tap_reg + 1'b1;
                        end
                    end
                    S_DONE:  state_reg <= S_IDLE;
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            logic [WW-1:0] w_q_reg;
            always_ff @(posedge clk) begin
                if (rst || clr_w)
                    w_q_reg <= '0;
                else if ((state_reg == S_UPD) && (tap_reg == IW'(gi)))
                    w_q_reg <= w_new;
            end
            assign w_flat[gi*WW +: WW] = w_q_reg;
        end
    endgenerate

    assign weight_out = w_flat;
    assign busy       = (state_reg == S_DIV) || (state_reg == S_UPD);
    assign done       = (state_reg == S_DONE);

endmodule

// File: tb/tb_nlms_weight_update.sv
// Directed bench for nlms_weight_update: hand-computed step/weight vectors,
// latency, skip path, saturation, ignored starts, clear and mid-run reset.
module tb_nlms_weight_update;

    localparam int TAPS = 32;
    localparam int DW   = 14;
    localparam int WW   = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [DW-1:0]       e = '0;
    logic [31:0]         n = '0;
    logic [TAPS*DW-1:0]  ref_flat = '0;
    logic                clr_w = 1'b0;
    logic                busy;
    logic                done;
    logic [TAPS*WW-1:0]  weight_out;

    int checks = 0;
    int errors = 0;

    nlms_weight_update #(.TAPS(TAPS), .DW(DW), .WW(WW), .FRAC(16), .MU_SHIFT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .e(e), .n(n), .ref_flat(ref_flat),
        .clr_w(clr_w), .busy(busy), .done(done), .weight_out(weight_out)
    );

    always #5 clk = ~clk;

    task automatic set_ref_all(input int val);
        for (int k = 0; k < TAPS; k++) ref_flat[k*DW +: DW] = DW'(val);
    endtask

    // Start sampled at edge T; returns #1 after edge T (cycle T+1).
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // cyc = number of edges after the start edge until done is seen (-1 on timeout).
    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b required busy=0 done=0", busy, done);
        end
        for (int k = 0; k < TAPS; k++) begin
            checks++;
            if (weight_out[k*WW +: WW] !== 16'sd0) begin
                errors++;
                $display("FAIL reset_w%0d got %0d required 0", k, $signed(weight_out[k*WW +: WW]));
            end
        end
        $display("test_reset: weights and flags after reset checked");
    endtask

    task automatic test_basic();
        int cyc;
        e = 14'sd1024; n = 32'd65536; set_ref_all(256);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b required 1", busy);
        end
        wait_done(200, cyc);
        checks++;
        if (cyc !== 62) begin
            errors++;
            $display("FAIL basic_latency got %0d required 62", cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_done got %b required 0", busy);
        end
        for (int k = 0; k < TAPS; k++) begin
            checks++;
            if ($signed(weight_out[k*WW +: WW]) !== 1024) begin
                errors++;
                $display("FAIL basic_w%0d got %0d required 1024", k, $signed(weight_out[k*WW +: WW]));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got %b required 0", done);
        end
        $display("test_basic: e=1024 n=65536 ref=256 done after %0d edges", cyc);
    endtask

    task automatic test_negative_and_saturate();
        int cyc;
        do_reset();
        e = -14'sd1024; n = 32'd65536; set_ref_all(256);
        pulse_start();
        wait_done(200, cyc);
        for (int k = 0; k < TAPS; k++) begin
            checks++;
            if ($signed(weight_out[k*WW +: WW]) !== -1024) begin
                errors++;
                $display("FAIL neg_w%0d got %0d required -1024", k, $signed(weight_out[k*WW +: WW]));
            end
        end
        $display("test_negative: e=-1024 run done after %0d edges", cyc);
        do_reset();
        e = 14'sd1024;
        for (int r = 1; r <= 32; r++) begin
            pulse_start();
            wait_done(200, cyc);
            checks++;
            if (cyc !== 62) begin
                errors++;
                $display("FAIL sat_latency run %0d got %0d required 62", r, cyc);
            end
            if (r == 31) begin
                checks++;
                if ($signed(weight_out[5*WW +: WW]) !== 31744) begin
                    errors++;
                    $display("FAIL sat_run31_w5 got %0d required 31744", $signed(weight_out[5*WW +: WW]));
                end
            end
        end
        for (int k = 0; k < TAPS; k++) begin
            checks++;
            if ($signed(weight_out[k*WW +: WW]) !== 32767) begin
                errors++;
                $display("FAIL sat_w%0d got %0d required 32767", k, $signed(weight_out[k*WW +: WW]));
            end
        end
        $display("test_saturate: 32 runs of +1024 accumulated to upper rail");
    endtask

    task automatic test_skip();
        int cyc;
        e = 14'sd500; n = 32'd0; set_ref_all(256);
        pulse_start();
        wait_done(200, cyc);
        checks++;
        if (cyc !== 32) begin
            errors++;
            $display("FAIL skip_n0_latency got %0d required 32", cyc);
        end
        checks++;
        if ($signed(weight_out[0 +: WW]) !== 32767 || $signed(weight_out[31*WW +: WW]) !== 32767) begin
            errors++;
            $display("FAIL skip_n0_w got w0=%0d w31=%0d required 32767", $signed(weight_out[0 +: WW]),
                     $signed(weight_out[31*WW +: WW]));
        end
        $display("test_skip: n=0 done after %0d edges", cyc);
        e = '0; n = 32'd65536;
        pulse_start();
        wait_done(200, cyc);
        checks++;
        if (cyc !== 32) begin
            errors++;
            $display("FAIL skip_e0_latency got %0d required 32", cyc);
        end
        checks++;
        if ($signed(weight_out[7*WW +: WW]) !== 32767) begin
            errors++;
            $display("FAIL skip_e0_w7 got %0d required 32767", $signed(weight_out[7*WW +: WW]));
        end
        $display("test_skip: e=0 done after %0d edges", cyc);
    endtask

    task automatic test_clamp();
        int cyc;
        int expw [4];
        do_reset();
        e = 14'sd8191; n = 32'd1; set_ref_all(0);
        // step clamps to 32767: 32767*-8192>>>8 saturates low, 32767*8191 saturates high,
        // 32767>>>8=127, -32767>>>8 floors to -128.
        ref_flat[0*DW +: DW] = -14'sd8192;
        ref_flat[1*DW +: DW] = 14'sd8191;
        ref_flat[2*DW +: DW] = 14'sd1;
        ref_flat[3*DW +: DW] = -14'sd1;
        expw[0] = -32768; expw[1] = 32767; expw[2] = 127; expw[3] = -128;
        pulse_start();
        wait_done(200, cyc);
        checks++;
        if (cyc !== 62) begin
            errors++;
            $display("FAIL clamp_latency got %0d required 62", cyc);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ($signed(weight_out[k*WW +: WW]) !== expw[k]) begin
                errors++;
                $display("FAIL clamp_w%0d got %0d required %0d", k, $signed(weight_out[k*WW +: WW]), expw[k]);
            end
        end
        checks++;
        if ($signed(weight_out[20*WW +: WW]) !== 0) begin
            errors++;
            $display("FAIL clamp_w20 got %0d required 0", $signed(weight_out[20*WW +: WW]));
        end
        $display("test_clamp: e=8191 n=1 done after %0d edges", cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int done_cnt;
        int done_at;
        do_reset();
        e = 14'sd1024; n = 32'd65536; set_ref_all(256);
        pulse_start();
        done_cnt = 0; done_at = -1;
        for (int i = 1; i <= 90; i++) begin
            start = (i == 5 || i == 40);
            if (i == 3) begin
                e = -14'sd3000; n = 32'd7; set_ref_all(-5);
            end
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
        end
        start = 1'b0;
        checks++;
        if (done_cnt !== 1 || done_at !== 62) begin
            errors++;
            $display("FAIL ignored_start done_count=%0d at=%0d required 1 at 62", done_cnt, done_at);
        end
        checks++;
        if ($signed(weight_out[9*WW +: WW]) !== 1024) begin
            errors++;
            $display("FAIL snapshot_w9 got %0d required 1024", $signed(weight_out[9*WW +: WW]));
        end
        $display("test_back_to_back: re-pulsed run gave %0d done pulse(s)", done_cnt);
        e = 14'sd1024; n = 32'd65536; set_ref_all(256);
        pulse_start();
        wait_done(200, cyc);
        pulse_start();
        wait_done(200, cyc);
        checks++;
        if (cyc !== 62) begin
            errors++;
            $display("FAIL chained_latency got %0d required 62", cyc);
        end
        checks++;
        if ($signed(weight_out[31*WW +: WW]) !== 3072) begin
            errors++;
            $display("FAIL chained_w31 got %0d required 3072", $signed(weight_out[31*WW +: WW]));
        end
        $display("test_back_to_back: start in DONE cycle chained, done after %0d edges", cyc);
    endtask

    task automatic test_clr();
        int done_cnt;
        pulse_start();
        done_cnt = 0;
        for (int i = 1; i <= 80; i++) begin
            clr_w = (i == 20);
            start = (i == 20);
            @(posedge clk); #1;
            clr_w = 1'b0; start = 1'b0;
            if (done) done_cnt++;
            if (i == 20) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_busy got %b required 0", busy);
                end
                checks++;
                if (weight_out !== '0) begin
                    errors++;
                    $display("FAIL clr_weights got w0=%0d required all 0", $signed(weight_out[0 +: WW]));
                end
            end
        end
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_done done_count=%0d busy=%b required 0 0", done_cnt, busy);
        end
        $display("test_clr: clear at T+20 aborted run, done pulses=%0d", done_cnt);
    endtask

    task automatic test_rst_mid();
        int cyc;
        e = 14'sd1024; n = 32'd65536; set_ref_all(256);
        pulse_start();
        for (int i = 1; i <= 45; i++) begin
            rst = (i == 45);
            @(posedge clk); #1;
            if (i == 44) begin
                checks++;
                if ($signed(weight_out[0 +: WW]) !== 1024 || $signed(weight_out[31*WW +: WW]) !== 0) begin
                    errors++;
                    $display("FAIL midupd_w got w0=%0d w31=%0d required 1024 0",
                             $signed(weight_out[0 +: WW]), $signed(weight_out[31*WW +: WW]));
                end
            end
        end
        rst = 1'b0;
        checks++;
        if (weight_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got w0=%0d busy=%b done=%b required 0 0 0",
                     $signed(weight_out[0 +: WW]), busy, done);
        end
        pulse_start();
        wait_done(200, cyc);
        checks++;
        if (cyc !== 62 || $signed(weight_out[17*WW +: WW]) !== 1024) begin
            errors++;
            $display("FAIL rst_recover got latency=%0d w17=%0d required 62 1024",
                     cyc, $signed(weight_out[17*WW +: WW]));
        end
        $display("test_rst_mid: reset during update, recovery run done after %0d edges", cyc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative_and_saturate();
        test_skip();
        test_clamp();
        test_back_to_back();
        test_clr();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
